elm_index_sequencer: RTL and testbench

- Parametrised two-level index sequencer for the ELM hidden/output-layer matrix-vector products.
- Inner counter walks column (product) indices; outer counter walks row (neuron) indices.
- A drain phase covers multiplier/accumulator latency, then a one-cycle done pulse.
- Generalises the single fixed 5-bit products counter: adds start/stall/abort control, modulus wrap, row-end flags and completion signalling.

---
 rtl/elm_index_sequencer_if.sv | 37 +++
 rtl/elm_index_sequencer.sv | 117 +++++++++++
 tb/tb_elm_index_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/elm_index_sequencer_if.sv
// Control inputs and index/status outputs of elm_index_sequencer; master is the sequencer side.
// ELM_SEQ_STALL_CNT_EN adds the 16-bit stall_cnt observation output.
interface elm_index_sequencer_if #(
    parameter int COL_W = 5,
    parameter int ROW_W = 5
);
    logic             start;
    logic             stall;
    logic             abort;
    logic [COL_W-1:0] col_idx;
    logic [ROW_W-1:0] row_idx;
    logic             idx_valid;
    logic             row_end;
    logic             busy;
    logic             done;
`ifdef ELM_SEQ_STALL_CNT_EN
    logic [15:0]      stall_cnt;

    modport master (
        input  start, stall, abort,
        output col_idx, row_idx, idx_valid, row_end, busy, done, stall_cnt
    );
    modport slave (
        output start, stall, abort,
        input  col_idx, row_idx, idx_valid, row_end, busy, done, stall_cnt
    );
`else
    modport master (
        input  start, stall, abort,
        output col_idx, row_idx, idx_valid, row_end, busy, done
    );
    modport slave (
        output start, stall, abort,
        input  col_idx, row_idx, idx_valid, row_end, busy, done
    );
`endif
endinterface

// File: rtl/elm_index_sequencer.sv
// Two-level column/row index walker with MUL_LAT drain and a one-cycle done pulse; stall holds indices in RUN.
// Indices/flags are registered state, idx_valid is combinational; ELM_SEQ_STALL_CNT_EN adds a saturating stall counter.
module elm_index_sequencer #(
    parameter int COL_W     = 5,
    parameter int ROW_W     = 5,
    parameter int COL_START = 1,
    parameter int COL_LAST  = 25,
    parameter int ROW_LAST  = 9,
    parameter int MUL_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    elm_index_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int DW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [COL_W-1:0] C_FIRST = COL_W'(COL_START);
    localparam logic [COL_W-1:0] C_LAST  = COL_W'(COL_LAST);
    localparam logic [ROW_W-1:0] R_LAST  = ROW_W'(ROW_LAST);
    localparam logic [DW-1:0]    D_LAST  = DW'((MUL_LAT > 0) ? MUL_LAT - 1 : 0);

    state_t           state, state_nxt;
    logic [COL_W-1:0] col_q, col_nxt;
    logic [ROW_W-1:0] row_q, row_nxt;
    logic [DW-1:0]    drain_q, drain_nxt;
    logic             idx_valid;
    logic             col_at_last;
    logic             last_pair;

    assign idx_valid   = (state == RUN) && !bus.stall;
    assign col_at_last = (col_q == C_LAST);
    assign last_pair   = idx_valid && col_at_last && (row_q == R_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            col_q   <= C_FIRST;
            row_q   <= '0;
            drain_q <= '0;
        end else begin
            state   <= state_nxt;
            col_q   <= col_nxt;
            row_q   <= row_nxt;
            drain_q <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col_q;
        row_nxt   = row_q;
        drain_nxt = drain_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    col_nxt   = C_FIRST;
                    row_nxt   = '0;
                end
            end
            RUN: begin
                // Final pair leaves the indices parked at (COL_LAST, ROW_LAST).
                if (last_pair) begin
                    drain_nxt = '0;
                    if (MUL_LAT > 0) state_nxt = DRAIN;
                    else             state_nxt = DONE;
                end else if (idx_valid) begin
                    if (col_at_last) begin
                        col_nxt = C_FIRST;
                        row_nxt = row_q + ROW_W'(1);
                    end else begin
                        col_nxt = col_q + COL_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == D_LAST) state_nxt = DONE;
                else                   drain_nxt = drain_q + DW'(1);
            end
            DONE: begin
                state_nxt = IDLE;
                col_nxt   = C_FIRST;
                row_nxt   = '0;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.abort) begin
            state_nxt = IDLE;
            col_nxt   = C_FIRST;
            row_nxt   = '0;
        end
    end

    assign bus.col_idx   = col_q;
    assign bus.row_idx   = row_q;
    assign bus.idx_valid = idx_valid;
    assign bus.row_end   = idx_valid && col_at_last;
    assign bus.busy      = (state == RUN) || (state == DRAIN);
    assign bus.done      = (state == DONE);

`ifdef ELM_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (state == IDLE && bus.start && !bus.abort) begin
            stall_cnt_q <= '0;
        end else if (state == RUN && bus.stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_elm_index_sequencer.sv
// Bench for elm_index_sequencer: default-parameter instance driven by random/directed runs against an
// arithmetic model, plus a small (0..3 x 0..1, MUL_LAT=0) instance driven from a per-cycle vector table.
module tb_elm_index_sequencer;
    localparam int CS = 1;
    localparam int CL = 25;
    localparam int RL = 9;
    localparam int ML = 2;
    localparam int NC = CL - CS + 1;
    localparam int N  = NC * (RL + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    elm_index_sequencer_if #(.COL_W(5), .ROW_W(5)) bus_a ();
    elm_index_sequencer_if #(.COL_W(5), .ROW_W(5)) bus_b ();

    elm_index_sequencer dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    elm_index_sequencer #(.COL_START(0), .COL_LAST(3), .ROW_LAST(1), .MUL_LAT(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Model of instance A: k = pairs issued so far, d = cycles since the final valid pair.
    bit act = 1'b0;
    int k = 0;
    int d = 0;
    int sc = 0;
    int cyc = 0, last_v = 0, done_c = 0, nvalid = 0, nrowend = 0;

    function automatic logic [13:0] out_a();
        return {bus_a.col_idx, bus_a.row_idx, bus_a.idx_valid, bus_a.row_end, bus_a.busy, bus_a.done};
    endfunction

    task automatic cycle_a(input bit s, input bit st, input bit ab);
        logic [13:0] exp;
        @(negedge clk);
        bus_a.start = s;
        bus_a.stall = st;
        bus_a.abort = ab;
        #1;
        if (!act)
            exp = {5'(CS), 5'd0, 4'b0000};
        else if (k < N)
            exp = {5'(CS + k % NC), 5'(k / NC), !st, (!st && (k % NC == NC - 1)), 1'b1, 1'b0};
        else if (d <= ML)
            exp = {5'(CL), 5'(RL), 4'b0010};
        else
            exp = {5'(CL), 5'(RL), 4'b0001};
        check("a_outs{col,row,vld,rend,busy,done}", out_a(), exp);
`ifdef ELM_SEQ_STALL_CNT_EN
        check("a_stall_cnt", bus_a.stall_cnt, sc);
`endif
        cyc++;
        if (bus_a.idx_valid) begin nvalid++; last_v = cyc; end
        if (bus_a.row_end) nrowend++;
        if (bus_a.done) done_c = cyc;
        if (act && k < N && st && sc < 65535) sc++;
        if (ab) act = 1'b0;
        else if (!act) begin
            if (s) begin act = 1'b1; k = 0; d = 0; sc = 0; end
        end else if (k < N) begin
            if (!st) begin k++; if (k == N) d = 1; end
        end else if (d == ML + 1) act = 1'b0;
        else d++;
    endtask

    task automatic run_a(input int stall_pct, input int abort_k, input int hold_k, input int hold_n);
        int budget = 0;
        int held = 0;
        cycle_a(1'b1, 1'b0, 1'b0);
        while (act && budget < 3000) begin
            bit st, ab, s;
            st = ($urandom_range(99) < stall_pct);
            if (k == hold_k && held < hold_n) begin st = 1'b1; held++; end
            ab = (abort_k >= 0 && k == abort_k);
            s  = 1'($urandom_range(1));
            cycle_a(s, st, ab);
            budget++;
        end
        if (budget >= 3000) begin
            checks++;
            failures++;
            $display("FAIL a_run_timeout got=busy expected=idle within 3000 cycles");
        end
    endtask

    typedef struct {
        logic       start, stall, abort;
        logic [4:0] col, row;
        logic       valid, rend, busy, done;
        logic [15:0] scnt;
    } vec_t;

    function automatic vec_t mk(input logic s, st, ab, input int c, r,
                                input logic v, re, b, dn, input int scv);
        vec_t t;
        t.start = s; t.stall = st; t.abort = ab;
        t.col = 5'(c); t.row = 5'(r);
        t.valid = v; t.rend = re; t.busy = b; t.done = dn;
        t.scnt = 16'(scv);
        return t;
    endfunction

    vec_t tbl [16];

    initial begin
        // Instance B: cols 0..3, rows 0..1, MUL_LAT=0.
        tbl[0]  = mk(1,0,0, 0,0, 0,0,0,0, 0);
        tbl[1]  = mk(0,0,0, 0,0, 1,0,1,0, 0);
        tbl[2]  = mk(0,0,0, 1,0, 1,0,1,0, 0);
        tbl[3]  = mk(0,0,0, 2,0, 1,0,1,0, 0);
        tbl[4]  = mk(0,0,0, 3,0, 1,1,1,0, 0);
        tbl[5]  = mk(0,0,0, 0,1, 1,0,1,0, 0);
        tbl[6]  = mk(0,1,0, 1,1, 0,0,1,0, 0);
        tbl[7]  = mk(1,0,0, 1,1, 1,0,1,0, 1);
        tbl[8]  = mk(0,0,0, 2,1, 1,0,1,0, 1);
        tbl[9]  = mk(0,0,0, 3,1, 1,1,1,0, 1);
        tbl[10] = mk(0,0,0, 3,1, 0,0,0,1, 1);
        tbl[11] = mk(1,0,1, 0,0, 0,0,0,0, 1);
        tbl[12] = mk(0,0,0, 0,0, 0,0,0,0, 1);
        tbl[13] = mk(1,0,0, 0,0, 0,0,0,0, 1);
        tbl[14] = mk(0,0,1, 0,0, 1,0,1,0, 0);
        tbl[15] = mk(0,0,0, 0,0, 0,0,0,0, 0);

        bus_a.start = 1'b0; bus_a.stall = 1'b0; bus_a.abort = 1'b0;
        bus_b.start = 1'b0; bus_b.stall = 1'b0; bus_b.abort = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("a_reset_state", out_a(), {5'd1, 5'd0, 4'b0000});
        check("b_reset_state", {bus_b.col_idx, bus_b.row_idx, bus_b.idx_valid, bus_b.row_end,
                                bus_b.busy, bus_b.done}, 14'd0);
`ifdef ELM_SEQ_STALL_CNT_EN
        check("a_reset_stall_cnt", bus_a.stall_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus_b.start = tbl[i].start;
            bus_b.stall = tbl[i].stall;
            bus_b.abort = tbl[i].abort;
            #1;
            check($sformatf("b_vec%0d{col,row,vld,rend,busy,done}", i),
                  {bus_b.col_idx, bus_b.row_idx, bus_b.idx_valid, bus_b.row_end, bus_b.busy, bus_b.done},
                  {tbl[i].col, tbl[i].row, tbl[i].valid, tbl[i].rend, tbl[i].busy, tbl[i].done});
`ifdef ELM_SEQ_STALL_CNT_EN
            check($sformatf("b_vec%0d_stall_cnt", i), bus_b.stall_cnt, tbl[i].scnt);
`endif
        end
        @(negedge clk);
        bus_b.start = 1'b0; bus_b.stall = 1'b0; bus_b.abort = 1'b0;

        // Clean full run: counts and done latency taken from the DUT outputs.
        cyc = 0; nvalid = 0; nrowend = 0; last_v = 0; done_c = 0;
        run_a(0, -1, -1, 0);
        check("a_valid_count", nvalid, N);
        check("a_row_end_count", nrowend, RL + 1);
        check("a_done_after_last_valid", done_c - last_v, ML + 1);

        // Four stall cycles at (7,2).
        run_a(0, -1, 2 * NC + (7 - CS), 4);
`ifdef ELM_SEQ_STALL_CNT_EN
        check("a_stall_cnt_at_done", bus_a.stall_cnt, 4);
`endif

        // Abort at (12,5), then a complete run.
        done_c = 0;
        run_a(0, 5 * NC + (12 - CS), -1, 0);
        check("a_no_done_on_abort", done_c, 0);
        cycle_a(1'b0, 1'b0, 1'b0);
        run_a(0, -1, -1, 0);

        for (int r = 0; r < 4; r++)
            run_a(int'($urandom_range(10, 50)), (r == 3) ? int'($urandom_range(0, N - 1)) : -1, -1, 0);

        // Asynchronous reset in the middle of DRAIN.
        begin
            int budget = 0;
            cycle_a(1'b1, 1'b0, 1'b0);
            while (act && k < N && budget < 600) begin
                cycle_a(1'b0, 1'b0, 1'b0);
                budget++;
            end
            @(posedge clk);
            #2;
            check("a_drain_busy", {bus_a.busy, bus_a.idx_valid, bus_a.done}, 3'b100);
            rst = 1'b1;
            #1;
            check("a_async_reset_outs", out_a(), {5'd1, 5'd0, 4'b0000});
`ifdef ELM_SEQ_STALL_CNT_EN
            check("a_async_reset_stall_cnt", bus_a.stall_cnt, 0);
`endif
            @(negedge clk);
            rst = 1'b0;
            act = 1'b0; sc = 0;
            cycle_a(1'b0, 1'b0, 1'b0);
            run_a(20, -1, -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
